// File: rtl/avmm_burst_bridge_pkg.sv
// Shared types and constants for the processor-bus to Avalon-MM burst bridge.
package avmm_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_WACK  = 3'd2,
        S_RCMD  = 3'd3,
        S_RDATA = 3'd4,
        S_RDONE = 3'd5
    } bridge_state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam int MAX_DATAWIDTH = 128;

    // Returned on the single read ack issued after a watchdog abort.
    localparam logic [MAX_DATAWIDTH-1:0] TMO_DATA = '1;

    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp != OKAY;
    endfunction

endpackage

// File: rtl/avmm_burst_bridge_if.sv
// Processor command bus and Avalon-MM manager bus bundles used by the burst bridge.
interface avmm_cmd_if #(
    parameter int ADDRWIDTH  = 32,
    parameter int DATAWIDTH  = 32,
    parameter int BURSTWIDTH = 8
);
    logic [ADDRWIDTH-1:0]   cmd_addr;
    logic [DATAWIDTH/8-1:0] cmd_be;
    logic [DATAWIDTH-1:0]   cmd_wdata;
    logic                   cmd_we;
    logic                   cmd_rd;
    logic [BURSTWIDTH-1:0]  cmd_burst;
    logic                   cmd_wrack;
    logic                   cmd_rdack;
    logic [DATAWIDTH-1:0]   cmd_rdata;
    logic                   err;
    logic                   tmo;
    logic                   err_clr;

    modport master (
        output cmd_addr, cmd_be, cmd_wdata, cmd_we, cmd_rd, cmd_burst, err_clr,
        input  cmd_wrack, cmd_rdack, cmd_rdata, err, tmo
    );

    modport slave (
        input  cmd_addr, cmd_be, cmd_wdata, cmd_we, cmd_rd, cmd_burst, err_clr,
        output cmd_wrack, cmd_rdack, cmd_rdata, err, tmo
    );
endinterface

interface avmm_av_if #(
    parameter int ADDRWIDTH  = 32,
    parameter int DATAWIDTH  = 32,
    parameter int BURSTWIDTH = 8
);
    logic [ADDRWIDTH-1:0]   av_address;
    logic [DATAWIDTH/8-1:0] av_byteenable;
    logic [BURSTWIDTH-1:0]  av_burstcount;
    logic                   av_write;
    logic [DATAWIDTH-1:0]   av_writedata;
    logic                   av_read;
    logic                   av_waitrequest;
    logic [DATAWIDTH-1:0]   av_readdata;
    logic                   av_readdatavalid;
    logic [1:0]             av_response;

    modport master (
        output av_address, av_byteenable, av_burstcount, av_write, av_writedata, av_read,
        input  av_waitrequest, av_readdata, av_readdatavalid, av_response
    );

    modport slave (
        input  av_address, av_byteenable, av_burstcount, av_write, av_writedata, av_read,
        output av_waitrequest, av_readdata, av_readdatavalid, av_response
    );
endinterface

// File: rtl/avmm_burst_bridge_wdog.sv
// No-progress watchdog: counts enabled cycles since the last clear and flags expiry.
module avmm_wdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, i_en, i_clr};
            assign o_expire = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] r_cnt;

            // Leaving the counted states clears the count so each wait starts fresh.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (i_clr || !i_en) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end

            assign o_expire = i_en && !i_clr && (r_cnt == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/avmm_burst_bridge.sv
// Bridges a held-request processor bus onto an Avalon-MM manager with bursts,
// back-pressure, response-error capture and a no-progress watchdog.
module avmm_burst_bridge
    import avmm_bridge_pkg::*;
#(
    parameter int ADDRWIDTH  = 32,
    parameter int DATAWIDTH  = 32,
    parameter int BURSTWIDTH = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic      clk,
    input  logic      rst,
    avmm_cmd_if.slave cmd,
    avmm_av_if.master av
);

    localparam int BEW = DATAWIDTH / 8;
    localparam logic [ADDRWIDTH-1:0] ADDR_MASK = ~ADDRWIDTH'(BEW - 1);

    bridge_state_t         r_state;
    bridge_state_t         w_next;
    logic [ADDRWIDTH-1:0]  r_addr;
    logic [BURSTWIDTH-1:0] r_bcnt;
    logic [BURSTWIDTH-1:0] r_remaining;
    logic [DATAWIDTH-1:0]  r_rdata;
    logic                  r_rdack;
    logic                  r_err;
    logic                  r_tmo;

    logic [BURSTWIDTH-1:0] w_burst;
    logic                  w_start;
    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic                  w_beat;
    logic                  w_last_beat;
    logic                  w_wd_en;
    logic                  w_wd_clr;
    logic                  w_expire;
    logic                  w_stray;

    assign w_burst     = (cmd.cmd_burst == '0) ? BURSTWIDTH'(1) : cmd.cmd_burst;
    assign w_start     = (r_state == S_IDLE) && (cmd.cmd_we || cmd.cmd_rd);
    assign w_wr_accept = (r_state == S_WR) && !av.av_waitrequest;
    assign w_rd_accept = (r_state == S_RCMD) && !av.av_waitrequest;
    assign w_beat      = (r_state == S_RDATA) && av.av_readdatavalid;
    assign w_last_beat = w_beat && (r_remaining == BURSTWIDTH'(1));
    assign w_stray     = (r_state == S_IDLE) && av.av_readdatavalid;
    assign w_wd_en     = (r_state == S_WR) || (r_state == S_RCMD) || (r_state == S_RDATA);
    assign w_wd_clr    = w_wr_accept || w_rd_accept || w_beat;

    avmm_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_wd_en),
        .i_clr    (w_wd_clr),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Write has priority in IDLE; a held read is picked up once the write burst ends.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd.cmd_we) begin
                    w_next = S_WR;
                end else if (cmd.cmd_rd) begin
                    w_next = S_RCMD;
                end
            end
            S_WR: begin
                if (w_expire || w_wr_accept) begin
                    w_next = S_WACK;
                end
            end
            S_WACK: begin
                w_next = (r_remaining == '0) ? S_IDLE : S_WR;
            end
            S_RCMD: begin
                if (w_expire) begin
                    w_next = S_RDONE;
                end else if (w_rd_accept) begin
                    w_next = S_RDATA;
                end
            end
            S_RDATA: begin
                if (w_expire || w_last_beat) begin
                    w_next = S_RDONE;
                end
            end
            S_RDONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // An abort zeroes remaining so WACK falls straight back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_bcnt      <= '0;
            r_remaining <= '0;
            r_rdata     <= '0;
            r_rdack     <= 1'b0;
        end else begin
            r_rdack <= 1'b0;
            if (w_start) begin
                r_addr      <= cmd.cmd_addr & ADDR_MASK;
                r_bcnt      <= w_burst;
                r_remaining <= w_burst;
            end
            if (w_expire) begin
                r_remaining <= '0;
                if (r_state != S_WR) begin
                    r_rdack <= 1'b1;
                    r_rdata <= TMO_DATA[DATAWIDTH-1:0];
                end
            end else if (w_wr_accept || w_beat) begin
                r_remaining <= r_remaining - BURSTWIDTH'(1);
            end
            if (w_beat) begin
                r_rdata <= av.av_readdata;
                r_rdack <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
            r_tmo <= 1'b0;
        end else if (cmd.err_clr) begin
            r_err <= 1'b0;
            r_tmo <= 1'b0;
        end else begin
            if (w_expire) begin
                r_err <= 1'b1;
                r_tmo <= 1'b1;
            end
            if ((w_beat && resp_is_error(av.av_response)) || w_stray) begin
                r_err <= 1'b1;
            end
        end
    end

    assign av.av_address    = r_addr;
    assign av.av_burstcount = r_bcnt;
    assign av.av_write      = (r_state == S_WR);
    assign av.av_read       = (r_state == S_RCMD);
    assign av.av_writedata  = (r_state == S_WR) ? cmd.cmd_wdata : '0;
    assign av.av_byteenable = ((r_state == S_WR) || (r_state == S_RCMD)) ? cmd.cmd_be : '0;

    assign cmd.cmd_wrack = (r_state == S_WACK);
    assign cmd.cmd_rdack = r_rdack;
    assign cmd.cmd_rdata = r_rdata;
    assign cmd.err       = r_err;
    assign cmd.tmo       = r_tmo;

endmodule
